// File: rtl/irq_encoder_8to3.sv
// Sequential 8-to-3 priority encoder: edge-detected requests latch as pending, and
// the highest-priority pending line is presented as a 3-bit code with a valid/ack handshake.
module irq_encoder_8to3 #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic e_i,
    input  logic i0_i,
    input  logic i1_i,
    input  logic i2_i,
    input  logic i3_i,
    input  logic i4_i,
    input  logic i5_i,
    input  logic i6_i,
    input  logic i7_i,
    input  logic ack_i,
    output logic b0_o,
    output logic b1_o,
    output logic b2_o,
    output logic v_o,
    output logic ovf_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] req;
    logic [7:0] edge_det;
    logic [7:0] clr;
    logic [7:0] prev_q;
    logic [7:0] pend_q, pend_d;
    logic [2:0] code_q, code_d;
    logic       ovf_q, ovf_d;

    assign req = {i7_i, i6_i, i5_i, i4_i, i3_i, i2_i, i1_i, i0_i};

    // clr marks the bit retired by an accepted handshake this cycle
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign edge_det[gi] = req[gi] & ~prev_q[gi];
            assign clr[gi]      = ack_i & (state_q == PRESENT) & (code_q == 3'(gi));
        end
    endgenerate

    function automatic logic [2:0] pick(input logic [7:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int n = 0; n < 8; n++)
                if (p[n]) idx = 3'(n);
        end else begin
            for (int n = 7; n >= 0; n--)
                if (p[n]) idx = 3'(n);
        end
        return idx;
    endfunction

    // A new edge wins over a same-cycle clear, so a re-request during ACK is kept
    always_comb begin
        pend_d = 8'd0;
        ovf_d  = 1'b0;
        if (e_i) begin
            pend_d = edge_det | (pend_q & ~clr);
            ovf_d  = ovf_q | (|(edge_det & pend_q & ~clr));
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (!e_i) begin
            state_d = IDLE;
            code_d  = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_q != 8'd0) begin
                        code_d  = pick(pend_q);
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            prev_q  <= 8'd0;
            pend_q  <= 8'd0;
            code_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= req;
            pend_q  <= pend_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign v_o   = (state_q == PRESENT);
    assign b0_o  = code_q[0];
    assign b1_o  = code_q[1];
    assign b2_o  = code_q[2];
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Bench for irq_encoder_8to3: both priority orders checked every cycle against a
// behavioural model, plus directed spot checks with fixed expected values.
module tb_irq_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e;
    logic       ack;
    logic [7:0] req;
    logic       hb0, hb1, hb2, hv, hovf;
    logic       lb0, lb1, lb2, lv, lovf;
    logic [2:0] hcode, lcode;

    int n_vec = 0;
    int n_mis = 0;

    // model state: index 0 = PRIORITY_HIGH=1, index 1 = PRIORITY_HIGH=0
    bit m_prev[8];
    bit m_pend[2][8];
    bit m_v[2];
    int m_code[2];
    bit m_ovf[2];

    always #5 clk = ~clk;

    irq_encoder_8to3 #(.PRIORITY_HIGH(1'b1)) dut_h (
        .clk_i(clk), .rst_n_i(rst_n), .e_i(e),
        .i0_i(req[0]), .i1_i(req[1]), .i2_i(req[2]), .i3_i(req[3]),
        .i4_i(req[4]), .i5_i(req[5]), .i6_i(req[6]), .i7_i(req[7]),
        .ack_i(ack), .b0_o(hb0), .b1_o(hb1), .b2_o(hb2), .v_o(hv), .ovf_o(hovf)
    );

    irq_encoder_8to3 #(.PRIORITY_HIGH(1'b0)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .e_i(e),
        .i0_i(req[0]), .i1_i(req[1]), .i2_i(req[2]), .i3_i(req[3]),
        .i4_i(req[4]), .i5_i(req[5]), .i6_i(req[6]), .i7_i(req[7]),
        .ack_i(ack), .b0_o(lb0), .b1_o(lb1), .b2_o(lb2), .v_o(lv), .ovf_o(lovf)
    );

    assign hcode = {hb2, hb1, hb0};
    assign lcode = {lb2, lb1, lb0};

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int choose(input int d);
        // d=0: largest pending index wins; d=1: smallest pending index wins
        int best = -1;
        for (int n = 0; n < 8; n++)
            if (m_pend[d][n] && (best < 0 || (d == 0 ? n > best : n < best))) best = n;
        return best;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            m_prev[n] = 1'b0;
            m_pend[0][n] = 1'b0;
            m_pend[1][n] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            m_v[d] = 1'b0; m_code[d] = 0; m_ovf[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit new_pend[8];
            bit accept;
            int pick;
            accept = ack && m_v[d];
            pick = choose(d);
            for (int n = 0; n < 8; n++) begin
                bit rise, retire;
                rise   = req[n] && !m_prev[n];
                retire = accept && (m_code[d] == n);
                if (rise && m_pend[d][n] && !retire) m_ovf[d] = 1'b1;
                new_pend[n] = rise ? 1'b1 : (retire ? 1'b0 : m_pend[d][n]);
            end
            if (!e) begin
                for (int n = 0; n < 8; n++) m_pend[d][n] = 1'b0;
                m_v[d] = 1'b0; m_code[d] = 0; m_ovf[d] = 1'b0;
            end else begin
                if (!m_v[d]) begin
                    if (pick >= 0) begin
                        m_v[d] = 1'b1;
                        m_code[d] = pick;
                    end
                end else if (ack) begin
                    m_v[d] = 1'b0;
                end
                for (int n = 0; n < 8; n++) m_pend[d][n] = new_pend[n];
            end
        end
        for (int n = 0; n < 8; n++) m_prev[n] = req[n];
    endtask

    task automatic check_model();
        chk("h_v",    9'(hv),    9'(m_v[0]));
        chk("h_code", 9'(hcode), 9'(m_code[0]));
        chk("h_ovf",  9'(hovf),  9'(m_ovf[0]));
        chk("l_v",    9'(lv),    9'(m_v[1]));
        chk("l_code", 9'(lcode), 9'(m_code[1]));
        chk("l_ovf",  9'(lovf),  9'(m_ovf[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    initial begin
        logic [8:0] hseq, lseq;
        int hcnt, lcnt;

        rst_n = 1'b0; e = 1'b1; ack = 1'b0; req = 8'd0;
        model_reset();
        #12;
        chk("rst_v",    9'(hv),    9'd0);
        chk("rst_code", 9'(hcode), 9'd0);
        chk("rst_ovf",  9'(hovf),  9'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_v", 9'(hv), 9'd0);

        // single request on I5
        req = 8'h20; tick(); req = 8'h00;
        chk("i5_lat_v", 9'(hv), 9'd0);
        tick();
        chk("i5_v", 9'(hv), 9'd1);
        chk("i5_code", 9'(hcode), 9'd5);
        repeat (3) tick();
        chk("i5_hold", 9'(hcode), 9'd5);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("i5_ack_v", 9'(hv), 9'd0);
        tick();
        chk("i5_empty_v", 9'(hv), 9'd0);

        // priority drain of I1, I4, I6 with ACK tied high
        req = 8'h52; tick(); req = 8'h00; ack = 1'b1;
        hseq = 0; lseq = 0; hcnt = 0; lcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (hv) begin hseq = (hseq << 3) | 9'(hcode); hcnt++; end
            if (lv) begin lseq = (lseq << 3) | 9'(lcode); lcnt++; end
        end
        ack = 1'b0;
        chk("drain_h_cnt", 9'(hcnt), 9'd3);
        chk("drain_h_seq", hseq, 9'b110_100_001);
        chk("drain_l_cnt", 9'(lcnt), 9'd3);
        chk("drain_l_seq", lseq, 9'b001_100_110);

        // stability while a higher-priority request arrives
        req = 8'h04; tick(); req = 8'h00; tick();
        req = 8'h80; tick(); req = 8'h00; tick();
        chk("stab_code", 9'(hcode), 9'd2);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("stab_next", 9'(hcode), 9'd7);
        ack = 1'b1; tick(); ack = 1'b0; tick();

        // overrun on a double pulse of I3
        req = 8'h08; tick(); req = 8'h00; tick();
        req = 8'h08; tick(); req = 8'h00; tick();
        chk("ovf_set", 9'(hovf), 9'd1);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("ovf_sticky", 9'(hovf), 9'd1);

        // enable drop flushes pending and OVF
        req = 8'h0E; tick(); req = 8'h00; tick();
        e = 1'b0; tick(); e = 1'b1;
        chk("en_v", 9'(hv), 9'd0);
        chk("en_ovf", 9'(hovf), 9'd0);
        chk("en_code", 9'(hcode), 9'd0);
        repeat (2) tick();
        chk("en_lost", 9'(hv), 9'd0);
        req = 8'h01; tick(); e = 1'b0; tick(); e = 1'b1;
        repeat (3) tick();
        chk("en_level", 9'(hv), 9'd0);
        req = 8'h00; tick();

        // re-request of the presented line during its ACK
        req = 8'h08; tick(); req = 8'h00; tick();
        ack = 1'b1; req = 8'h08; tick(); ack = 1'b0; req = 8'h00;
        chk("rereq_ovf", 9'(hovf), 9'd0);
        tick();
        chk("rereq_v", 9'(hv), 9'd1);
        chk("rereq_code", 9'(hcode), 9'd3);
        ack = 1'b1; tick(); ack = 1'b0; tick();

        // asynchronous reset while a code is presented
        req = 8'h10; tick(); req = 8'h00; tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_v", 9'(hv), 9'd0);
        chk("arst_code", 9'(hcode), 9'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_idle", 9'(hv), 9'd0);

        // randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            req = 8'($urandom & $urandom & $urandom);
            ack = 1'($urandom_range(0, 1));
            e   = ($urandom_range(0, 31) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
